// File: rtl/inv_sub_bytes.sv
// Iterative AES InvSubBytes engine for the decrypt round.
//
// Accepts a 128-bit state on the input valid/ready handshake, replaces every byte with its
// FIPS-197 inverse S-box value, LANES bytes per clock, and offers the result on the output
// valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   n_rst      synchronous active-low reset
//   in_valid   in_state is valid
//   in_ready   block accepts in_state this cycle
//   in_state   input state, byte i = in_state[8i+7:8i]
//   out_valid  out_state holds a complete result
//   out_ready  downstream takes out_state this cycle
//   out_state  transformed state, same byte mapping
//   busy       high while a transfer is in flight (RUN or DONE)

module inv_sub_bytes #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if ((LANES != 1) && (LANES != 2) && (LANES != 4) && (LANES != 8) && (LANES != 16)) begin
        : g_bad_lanes
        $error("inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam int unsigned STEPS = 16 / LANES;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    // Inverse S-box, one 128-bit row per high nibble; column 0 sits in the top byte.
    localparam logic [127:0] INV_SBOX_ROWS [16] = '{
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [127:0] row;
        row = INV_SBOX_ROWS[b[7:4]];
        return row[{~b[3:0], 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [127:0]  work_q, work_d;
    logic [127:0]  work_sub;
    logic [3:0]    base;
    logic [7:0]    sub_byte [LANES];

    // Index of the first byte handled this step.
    assign base = 4'(cnt_q * LANES);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign sub_byte[g] = inv_sbox(work_q[{base + 4'(g), 3'b000} +: 8]);
    end

    // Working register with the current group of bytes substituted.
    always_comb begin
        work_sub = work_q;
        for (int l = 0; l < int'(LANES); l++) begin
            work_sub[{base + 4'(l), 3'b000} +: 8] = sub_byte[l];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                work_d = work_sub;
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                out_valid = 1'b1;
                // A new state may only enter in the cycle the result leaves.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        work_d  = in_state;
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign out_state = work_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/inv_sub_bytes.md
Name: inv_sub_bytes

Overview:
Iterative AES InvSubBytes engine for the decryption datapath. It accepts a 128-bit state over a valid/ready handshake and replaces every byte with its AES inverse S-box value. It processes LANES bytes per clock and returns the result over a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the decrypt round, and is the inverse of the encrypt-side byte substitution.

Parameters:
LANES, 4, bytes substituted per clock; legal values 1, 2, 4, 8, 16; any other value is a compile-time error.

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  reset, synchronous, active-low
in_valid  input  1  in_state valid
in_ready  output  1  block can accept in_state this cycle
in_state  input  128  state to transform; byte i = in_state[8i+7:8i], i=0..15
out_valid  output  1  out_state holds a complete result
out_ready  input  1  downstream accepts out_state this cycle
out_state  output  128  transformed state, same byte mapping
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: sampled on the rising clk edge while n_rst=0. Result:
  - FSM goes to IDLE; byte counter = 0; working register = 128'h0.
  - out_valid=0, in_ready=1 (IDLE), busy=0, out_state=128'h0.
  - A reset mid-RUN or mid-DONE aborts and discards the transfer; there is no partial output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: load the working register with in_state, set counter=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, bytes counter*LANES .. counter*LANES+LANES-1 of the working register are replaced by InvSbox(byte); counter increments.
  - After the cycle that processes bytes 16-LANES..15, go to DONE and reset counter to 0.
  - in_valid is ignored in RUN.
- DONE:
  - out_valid=1; out_state is held stable until out_ready.
  - in_ready = out_ready; a new input is accepted only in the same cycle the result is taken.
  - out_ready && in_valid: load the new in_state, go to RUN (back-to-back; no IDLE bubble).
  - out_ready && !in_valid: go to IDLE.
  - !out_ready: stay in DONE; the result is unchanged.
- out_state is driven directly from the working register; it is meaningful only while out_valid=1.
- Latency: acceptance on edge E0 gives out_valid=1 after edge E(16/LANES). That is 4 cycles for LANES=4 and 1 cycle for LANES=16.
- Throughput: one state per 16/LANES cycles with out_ready held high.
- InvSbox: the standard FIPS-197 inverse S-box, realised as a 256-entry constant table, instantiated LANES times and combinational.
  - InvSbox(Sbox(x)) = x for all 256 x.
  - Anchor values: InvSbox(00)=52, InvSbox(01)=09, InvSbox(63)=00, InvSbox(16)=FF, InvSbox(ED)=53.
- Counter width: clog2(16/LANES), minimum 1 bit; it wraps to 0 on leaving RUN.
- Handshake rules:
  - Source must hold in_state stable while in_valid && !in_ready.
  - The block never drops out_valid without out_ready.
  - in_valid=1 with in_ready=0 has no effect.

Test Plan:
- Reset/idle: n_rst=0 for 2 cycles, then 1 → out_valid=0, in_ready=1, busy=0, out_state=128'h0.
- Row-0 inverse, LANES=4: in_state bytes 0..15 = 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76, out_ready=1 → out_valid=1 exactly 4 cycles after acceptance, out_state bytes 0..15 = 00 01 02 … 0F, busy=1 for those cycles.
- Exhaustive/boundary: sixteen transfers covering all 256 byte values, each byte equal to Sbox(x), checked across LANES=1, 4 and 16 → each out byte = x. Also all-00 input → all bytes 52; all-16 input → all FF. Latency is 16 cycles (LANES=1) and 1 cycle (LANES=16).
- Backpressure: out_ready=0 for 5 cycles after out_valid with in_valid=1 held → out_state stable, in_ready=0, no second acceptance. Raising out_ready → result handed over and new input accepted in the same cycle; the next out_valid follows 16/LANES cycles later.
- Back-to-back: 8 consecutive inputs with in_valid and out_ready held high → 8 outputs in order, one every 16/LANES cycles, no IDLE cycles between them.
- Mid-operation reset: n_rst=0 during RUN (after 2 of 4 steps) → next cycle IDLE, out_valid=0, out_state=0. The following transfer (all ED) completes correctly → all bytes 53.
